// File: rtl/spike_aer_encoder.sv
// Purpose : serialise a parallel spike vector into a one-event-per-cycle AER stream {addr, ts}.
// Latency : 2 edges from capturing a vector to its first event showing on aer_valid.
// Backpr. : valid/ready at the output; a full FIFO stalls the scanner, which holds its pending bits.
//
// Ports: clk, rst (async active-low), en (capture enable + timestamp advance), spikes_in,
//        aer_valid/aer_ready/aer_addr/aer_ts (FWFT event FIFO head), busy (scan in progress),
//        drop_count (vectors discarded while scanning).
// Optional feature: define SPIKE_AER_DROP_COUNT_EN to build the 16-bit saturating drop counter;
// otherwise drop_count is tied to 0. Vectors arriving mid-scan are discarded either way.

// Purpose : generic first-word-fall-through FIFO.
// Latency : a push is visible at the head on the edge after it is written.
// Backpr. : pushes are ignored when full, pops are ignored when empty.
module spike_aer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Storage is not reset, so the head reads as zero while empty.
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A write never lands on the head slot while not full, so the head stays stable under stall.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module spike_aer_encoder #(
  parameter int NUM_SPIKES = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 16,
  parameter int ADDR_W     = $clog2(NUM_SPIKES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_SPIKES-1:0] spikes_in,
  output logic                  aer_valid,
  input  logic                  aer_ready,
  output logic [ADDR_W-1:0]     aer_addr,
  output logic [TS_WIDTH-1:0]   aer_ts,
  output logic                  busy,
  output logic [15:0]           drop_count
);
  typedef enum logic {IDLE, SCAN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [TS_WIDTH-1:0] ts;
  } event_t;

  state_t                state, state_nxt;
  logic [NUM_SPIKES-1:0] pending, pending_nxt, pending_clr;
  logic [TS_WIDTH-1:0]   ts, cap_ts, cap_ts_nxt;
  logic [ADDR_W-1:0]     scan_idx;
  logic                  push;
  logic                  fifo_empty, fifo_full;
  event_t                push_ev, head_ev;

  // Free-running capture timestamp, frozen while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    ts <= '0;
    else if (en) ts <= ts + TS_WIDTH'(1);
  end

  // Lowest set bit wins: scan downwards so the last match is the smallest index.
  always_comb begin
    scan_idx = '0;
    for (int i = NUM_SPIKES - 1; i >= 0; i--) begin
      if (pending[i]) scan_idx = ADDR_W'(i);
    end
  end

  // x & (x-1) clears exactly the lowest set bit.
  assign pending_clr = pending & (pending - NUM_SPIKES'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pending <= '0;
      cap_ts  <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      cap_ts  <= cap_ts_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    cap_ts_nxt  = cap_ts;
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (en && (spikes_in != '0)) begin
          pending_nxt = spikes_in;
          cap_ts_nxt  = ts;
          state_nxt   = SCAN;
        end
      end
      SCAN: begin
        if (!fifo_full) begin
          push        = 1'b1;
          pending_nxt = pending_clr;
          if (pending_clr == '0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push_ev = '{addr: scan_idx, ts: cap_ts};

  spike_aer_fifo #(
    .WIDTH($bits(event_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_ev),
    .pop      (aer_ready),
    .head_dat (head_ev),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign aer_valid = !fifo_empty;
  assign aer_addr  = head_ev.addr;
  assign aer_ts    = head_ev.ts;
  assign busy      = (state == SCAN);

`ifdef SPIKE_AER_DROP_COUNT_EN
  logic [15:0] drop_cnt;

  // Counts every offered vector seen while scanning, including the final-push edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if ((state == SCAN) && en && (spikes_in != '0) && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = '0;
`endif
endmodule
